// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StBytes,
    StWrite,
    StCheck,
    StDone,
    StError
  } state_e;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CHECKSUM_W     = 8;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Big-endian byte-to-word packer: shifts accepted bytes in at the LSB end and flags
// the transfer that completes a word.
module inst_loader_byte_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byteIn,
  input  logic        byteFire,
  output logic [31:0] word,
  output logic        wordReady
);

  localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

  logic [CntW-1:0] cntQ;
  logic [31:0]     wordQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      cntQ  <= '0;
      wordQ <= '0;
    end else if (clear) begin
      cntQ <= '0;
    end else if (byteFire) begin
      cntQ  <= cntQ + 1'b1;
      wordQ <= {wordQ[23:0], byteIn};
    end
  end

  // Asserted in the cycle the last byte of a word transfers; the word is complete next cycle.
  always_comb begin
    wordReady = byteFire && (cntQ == CntW'(BYTES_PER_WORD - 1));
    word      = wordQ;
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream into 32-bit words and
// writes them from address 0 while stalling the CPU. Optional INST_LOADER_CHECKSUM_EN adds
// a trailing XOR checksum byte.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  if (WORD_W != 32) begin : gen_word_w_check
    $error("inst_loader: WORD_W must be 32");
  end

  localparam int unsigned MaxWords = 32'd1 << ADDR_W;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_e PayloadEnd = StCheck;
`else
  localparam state_e PayloadEnd = StDone;
`endif

  state_e            stateQ, stateD;
  logic [15:0]       lenQ, lenD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [ADDR_W:0]   cntQ, cntD;
  logic              byteFire, packClear, packFire, wordReady;
  logic [31:0]       packWord;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [CHECKSUM_W-1:0] chkQ, chkD;
`endif

  assign byteFire = byte_valid && byte_ready;
  assign packFire = byteFire && (stateQ == StBytes);

  inst_loader_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (packClear),
    .byteIn   (byte_in),
    .byteFire (packFire),
    .word     (packWord),
    .wordReady(wordReady)
  );

  always_comb begin
    stateD    = stateQ;
    lenD      = lenQ;
    addrD     = addrQ;
    cntD      = cntQ;
    packClear = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    chkD      = chkQ;
`endif
    unique case (stateQ)
      StIdle, StDone, StError: begin
        if (start) begin
          stateD    = StLenHi;
          addrD     = '0;
          cntD      = '0;
          packClear = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
          chkD      = '0;
`endif
        end
      end
      StLenHi: begin
        if (byteFire) begin
          lenD   = {byte_in, lenQ[7:0]};
          stateD = StLenLo;
        end
      end
      StLenLo: begin
        if (byteFire) begin
          lenD = {lenQ[15:8], byte_in};
          if (lenD == 16'd0)                 stateD = PayloadEnd;
          else if (32'(lenD) > MaxWords)     stateD = StError;
          else                               stateD = StBytes;
        end
      end
      StBytes: begin
        if (byteFire) begin
`ifdef INST_LOADER_CHECKSUM_EN
          chkD = chkQ ^ byte_in;
`endif
          if (wordReady) stateD = StWrite;
        end
      end
      StWrite: begin
        addrD  = addrQ + 1'b1;
        cntD   = cntQ + 1'b1;
        stateD = (32'(cntD) == 32'(lenQ)) ? PayloadEnd : StBytes;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      StCheck: begin
        if (byteFire) stateD = (byte_in == chkQ) ? StDone : StError;
      end
`endif
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
      lenQ   <= '0;
      addrQ  <= '0;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      lenQ   <= lenD;
      addrQ  <= addrD;
      cntQ   <= cntD;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) chkQ <= '0;
    else     chkQ <= chkD;
  end
`endif

  always_comb begin
    byte_ready = (stateQ == StLenHi) || (stateQ == StLenLo) || (stateQ == StBytes) ||
                 (stateQ == StCheck);
    wr_en      = (stateQ == StWrite);
    cpu_hold   = byte_ready || wr_en;
    done       = (stateQ == StDone);
    err        = (stateQ == StError);
    wr_addr    = addrQ;
    wr_data    = packWord;
    word_count = cntQ;
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader; expected writes and outcome are derived
// from the frame bytes. Build with INST_LOADER_CHECKSUM_EN to cover the checksum variant.
module tb_inst_loader;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int errors = 0;

  // Driver-owned, monitor-read.
  bit restart = 1'b0;
  int frameN  = 0;

  // Monitor-owned, driver-read.
  int                xferIdx = 0;
  bit                expWr   = 1'b0;
  logic [ADDR_W-1:0] obsAddr[$];
  logic [31:0]       obsData[$];

  always #5 clk = ~clk;

  inst_loader #(
    .ADDR_W(ADDR_W),
    .WORD_W(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .word_count(word_count)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit isWordEnd(input int idx, input int n);
    return (idx >= 2) && (idx < 2 + 4 * n) && (((idx - 2) % 4) == 3);
  endfunction

  function automatic byte_q_t bytesOf(input logic [127:0] v, input int cnt);
    byte_q_t r;
    for (int i = cnt - 1; i >= 0; i--) r.push_back(v[8*i +: 8]);
    return r;
  endfunction

  // Appends the XOR of the payload (optionally corrupted) when checksums are enabled.
  function automatic byte_q_t addCheck(input byte_q_t fb, input logic [7:0] flip);
    byte_q_t    r = fb;
    logic [7:0] x = 8'h00;
    for (int i = 2; i < fb.size(); i++) x ^= fb[i];
    if (CHK_EN) r.push_back(x ^ flip);
    return r;
  endfunction

  // Write must follow each word-completing transfer by exactly one cycle.
  always @(negedge clk) begin
    checkVal("wr_en_timing", wr_en, expWr);
    if (wr_en) begin
      obsAddr.push_back(wr_addr);
      obsData.push_back(wr_data);
    end
    if (cpu_hold) checkVal("ready_low_only_in_write", byte_ready, !wr_en);
    if (rst || restart) begin
      xferIdx = 0;
      expWr   = 1'b0;
    end else begin
      expWr = byte_valid && byte_ready && isWordEnd(xferIdx, frameN);
      if (byte_valid && byte_ready) xferIdx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input int n);
    frameN  = n;
    start   = 1'b1;
    restart = 1'b1;
    tick();
    start   = 1'b0;
    restart = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, input bit poke);
    bit ok = 1'b0;
    byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = poke && (g == 0);
      tick();
      start = 1'b0;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = byte_ready;
      tick();
    end
    byte_valid = 1'b0;
    checkVal("byte_accepted", ok, 1'b1);
  endtask

  task automatic checkAllZero(input string name);
    checkVal({name, ":byte_ready"}, byte_ready, 0);
    checkVal({name, ":wr_en"}, wr_en, 0);
    checkVal({name, ":wr_addr"}, wr_addr, 0);
    checkVal({name, ":wr_data"}, wr_data, 0);
    checkVal({name, ":cpu_hold"}, cpu_hold, 0);
    checkVal({name, ":done"}, done, 0);
    checkVal({name, ":err"}, err, 0);
    checkVal({name, ":word_count"}, word_count, 0);
  endtask

  task automatic runFrame(input string name, input byte_q_t fb, input int gapLo, input int gapHi,
                          input bit poke);
    int          n;
    int          nWr;
    int          base;
    int          got;
    bit          expErr;
    bit          fin = 1'b0;
    logic [7:0]  x   = 8'h00;
    logic [31:0] w;
    n      = int'({fb[0], fb[1]});
    nWr    = n;
    expErr = 1'b0;
    if (n > MAX_WORDS) begin
      expErr = 1'b1;
      nWr    = 0;
    end else if (CHK_EN) begin
      for (int i = 0; i < 4 * n; i++) x ^= fb[2+i];
      expErr = (fb[2+4*n] != x);
    end
    base = obsAddr.size();
    pulseStart(n);
    for (int i = 0; i < fb.size(); i++)
      sendByte(fb[i], int'($urandom_range(gapHi, gapLo)), poke && (i == 3));
    for (int c = 0; c < 10 && !fin; c++) begin
      @(negedge clk);
      fin = done || err;
      if (!fin) tick();
    end
    checkVal({name, ":finished"}, fin, 1'b1);
    checkVal({name, ":done"}, done, !expErr);
    checkVal({name, ":err"}, err, expErr);
    checkVal({name, ":cpu_hold"}, cpu_hold, 0);
    checkVal({name, ":byte_ready"}, byte_ready, 0);
    checkVal({name, ":word_count"}, word_count, nWr);
    got = obsAddr.size() - base;
    checkVal({name, ":num_writes"}, got, nWr);
    for (int i = 0; i < got && i < nWr; i++) begin
      w = {fb[2+4*i], fb[3+4*i], fb[4+4*i], fb[5+4*i]};
      checkVal({name, ":wr_addr"}, obsAddr[base+i], i);
      checkVal({name, ":wr_data"}, obsData[base+i], w);
    end
    tick();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q_t basic;
    byte_q_t fb;
    int      n;

    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");
    tick();

    basic = addCheck(bytesOf(128'h0002_2008_0005_AC09_0004, 10), 8'h00);
    runFrame("basic", basic, 0, 0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    checkVal("basic:done_held", done, 1'b1);
    tick();

    runFrame("backpressure", basic, 3, 3, 1'b1);

    runFrame("empty", addCheck(bytesOf(128'h0000, 2), 8'h00), 0, 1, 1'b0);

    runFrame("overlength", bytesOf(128'h0101, 2), 0, 0, 1'b0);

    // Abort mid-word, then reload from address 0.
    pulseStart(2);
    sendByte(8'h00, 0, 1'b0);
    sendByte(8'h02, 0, 1'b0);
    sendByte(8'h20, 0, 1'b0);
    sendByte(8'h08, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("mid_reset");
    tick();
    runFrame("after_reset", basic, 0, 1, 1'b0);

`ifdef INST_LOADER_CHECKSUM_EN
    runFrame("chk_mismatch", bytesOf(128'h0001_2008_0005_00, 7), 0, 0, 1'b0);
`endif

    for (int f = 0; f < 24; f++) begin
      fb = {};
      n  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(400, MAX_WORDS + 1))
                                       : int'($urandom_range(6, 0));
      fb.push_back(8'(n >> 8));
      fb.push_back(8'(n));
      if (n <= MAX_WORDS) begin
        for (int i = 0; i < 4 * n; i++) fb.push_back(8'($urandom));
        fb = addCheck(fb, ($urandom_range(3, 0) == 0) ? 8'h5A : 8'h00);
      end
      runFrame("random", fb, 0, 2, 1'b0);
    end

    // Largest legal program fills the whole memory.
    fb = {};
    fb.push_back(8'(MAX_WORDS >> 8));
    fb.push_back(8'(MAX_WORDS));
    for (int i = 0; i < 4 * MAX_WORDS; i++) fb.push_back(8'($urandom));
    runFrame("full_memory", addCheck(fb, 8'h00), 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
